// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
// Purpose: FSM state and owner enums plus latency-counter sizing shared by
//          mem_port_arbiter and rr_arbiter2.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } ArbState_t;

  typedef enum logic {
    OWN_CORE,
    OWN_DBG
  } Owner_t;

  localparam int MEM_LATENCY_MAX = 4;
  // Counter must hold MEM_LATENCY_MAX itself, hence the +1.
  localparam int CNT_W = $clog2(MEM_LATENCY_MAX + 1);

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-input round-robin grant with last-owner register
// Purpose: grants one of two requesters while enabled; on a tie the port not
//          served last wins. Last owner resets to OWN_DBG so the core wins
//          the first tie.
// Ports:   i_Clk, i_Reset (async, active-low)
//          i_Enable         grant window (arbiter idle)
//          i_Req0/i_Req1    core / debug requests
//          o_Gnt0/o_Gnt1    combinational grants, never both
//          o_Last           owner of the most recent grant
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic   i_Clk,
  input  logic   i_Reset,
  input  logic   i_Enable,
  input  logic   i_Req0,
  input  logic   i_Req1,
  output logic   o_Gnt0,
  output logic   o_Gnt1,
  output Owner_t o_Last
);

  Owner_t last_owner;

  assign o_Last = last_owner;

  // Gated with i_Reset so no grant can escape while reset is held.
  always_comb begin
    o_Gnt0 = 1'b0;
    o_Gnt1 = 1'b0;
    if (i_Enable && i_Reset) begin
      if (i_Req0 && (!i_Req1 || last_owner == OWN_DBG)) begin
        o_Gnt0 = 1'b1;
      end else if (i_Req1) begin
        o_Gnt1 = 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      last_owner <= OWN_DBG;
    end else if (o_Gnt0) begin
      last_owner <= OWN_CORE;
    end else if (o_Gnt1) begin
      last_owner <= OWN_DBG;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - core/debug arbiter and sequencer for the unified memory
// Purpose: shares a single-port memory between the core and a debug/loader
//          port. Each granted access runs IDLE -> ISSUE -> WAIT -> RESP, with
//          WAIT lasting MEM_LATENCY cycles.
// Ports:   i_Clk, i_Reset (async, active-low)
//          i_Core*/i_Dbg*   request, we, byte address, write data
//          o_*Gnt           combinational accept, o_*Done one-cycle completion
//          o_*RData         read data, held until that port's next Done
//          o_CoreStall      core request outstanding and not completing
//          o_Mem*/i_MemRData memory macro interface
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic              i_CoreReq,
  input  logic              i_CoreWe,
  input  logic [ADDR_W-1:0] i_CoreAdr,
  input  logic [DATA_W-1:0] i_CoreWData,
  input  logic              i_DbgReq,
  input  logic              i_DbgWe,
  input  logic [ADDR_W-1:0] i_DbgAdr,
  input  logic [DATA_W-1:0] i_DbgWData,
  output logic              o_CoreGnt,
  output logic              o_DbgGnt,
  output logic              o_CoreDone,
  output logic              o_DbgDone,
  output logic [DATA_W-1:0] o_CoreRData,
  output logic [DATA_W-1:0] o_DbgRData,
  output logic              o_CoreStall,
  output logic              o_MemEn,
  output logic              o_MemWe,
  output logic [ADDR_W-1:0] o_MemAdr,
  output logic [DATA_W-1:0] o_MemWData,
  input  logic [DATA_W-1:0] i_MemRData
);

  ArbState_t         state;
  ArbState_t         state_next;
  Owner_t            owner;
  logic [CNT_W-1:0]  lat_cnt;
  logic [ADDR_W-1:0] cap_adr;
  logic [DATA_W-1:0] cap_wdata;
  logic              cap_we;
  logic [DATA_W-1:0] core_rdata;
  logic [DATA_W-1:0] dbg_rdata;
  logic              gnt_core;
  logic              gnt_dbg;

  // The arbiter's last-owner register doubles as the owner of the access in
  // flight: it is only updated on a grant, which happens only in IDLE.
  rr_arbiter2 u_rr (
    .i_Clk    (i_Clk),
    .i_Reset  (i_Reset),
    .i_Enable (state == IDLE),
    .i_Req0   (i_CoreReq),
    .i_Req1   (i_DbgReq),
    .o_Gnt0   (gnt_core),
    .o_Gnt1   (gnt_dbg),
    .o_Last   (owner)
  );

  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (gnt_core || gnt_dbg) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (lat_cnt == CNT_W'(1)) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      lat_cnt    <= '0;
      cap_adr    <= '0;
      cap_wdata  <= '0;
      cap_we     <= 1'b0;
      core_rdata <= '0;
      dbg_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_core) begin
            cap_adr   <= i_CoreAdr;
            cap_wdata <= i_CoreWData;
            cap_we    <= i_CoreWe;
          end else if (gnt_dbg) begin
            cap_adr   <= i_DbgAdr;
            cap_wdata <= i_DbgWData;
            cap_we    <= i_DbgWe;
          end
        end
        ISSUE: lat_cnt <= CNT_W'(MEM_LATENCY);
        WAIT: begin
          lat_cnt <= lat_cnt - CNT_W'(1);
          // Count of 1 marks the cycle the memory's read data is valid.
          if (lat_cnt == CNT_W'(1) && !cap_we) begin
            if (owner == OWN_CORE) core_rdata <= i_MemRData;
            else                   dbg_rdata  <= i_MemRData;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_CoreGnt   = gnt_core;
  assign o_DbgGnt    = gnt_dbg;
  assign o_CoreDone  = (state == RESP) && (owner == OWN_CORE);
  assign o_DbgDone   = (state == RESP) && (owner == OWN_DBG);
  assign o_CoreRData = core_rdata;
  assign o_DbgRData  = dbg_rdata;
  assign o_CoreStall = i_CoreReq && !o_CoreDone;
  assign o_MemEn     = (state == ISSUE);
  assign o_MemWe     = (state == ISSUE) && cap_we;
  assign o_MemAdr    = cap_adr;
  assign o_MemWData  = cap_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter (latency 1 and 3)
module tb_mem_port_arbiter;

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rstn    [2];
  logic        req     [2][2];
  logic        we      [2][2];
  logic [31:0] adr     [2][2];
  logic [31:0] wd      [2][2];
  logic        gnt     [2][2];
  logic        done    [2][2];
  logic [31:0] rd      [2][2];
  logic        stall   [2];
  logic        mem_en  [2];
  logic        mem_we  [2];
  logic [31:0] mem_adr [2];
  logic [31:0] mem_wd  [2];
  logic [31:0] mem_rd  [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MEM_LATENCY((g == 0) ? 1 : 3)
    ) u_dut (
      .i_Clk       (clk),
      .i_Reset     (rstn[g]),
      .i_CoreReq   (req[g][0]),
      .i_CoreWe    (we[g][0]),
      .i_CoreAdr   (adr[g][0]),
      .i_CoreWData (wd[g][0]),
      .i_DbgReq    (req[g][1]),
      .i_DbgWe     (we[g][1]),
      .i_DbgAdr    (adr[g][1]),
      .i_DbgWData  (wd[g][1]),
      .o_CoreGnt   (gnt[g][0]),
      .o_DbgGnt    (gnt[g][1]),
      .o_CoreDone  (done[g][0]),
      .o_DbgDone   (done[g][1]),
      .o_CoreRData (rd[g][0]),
      .o_DbgRData  (rd[g][1]),
      .o_CoreStall (stall[g]),
      .o_MemEn     (mem_en[g]),
      .o_MemWe     (mem_we[g]),
      .o_MemAdr    (mem_adr[g]),
      .o_MemWData  (mem_wd[g]),
      .i_MemRData  (mem_rd[g])
    );
  end

  // Memory model: read data valid only in the cycle MEM_LATENCY after MemEn,
  // garbage otherwise; a reset cancels a pending read.
  logic [31:0] mem [2][256];
  bit          pend [2];
  int          pend_cyc [2];
  logic [31:0] pend_adr [2];
  bit          loaded = 0;

  always @(negedge clk) begin
    if (!loaded) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 256; i++) mem[k][i] = 32'h0;
        mem[k][16] = 32'hDEADBEEF;
        mem[k][32] = 32'hCAFEF00D;
        mem[k][4]  = 32'h11112222;
        pend[k] = 0;
      end
      loaded = 1;
    end
    for (int k = 0; k < 2; k++) begin
      if (!rstn[k]) pend[k] = 0;
      if (pend[k] && cyc == pend_cyc[k] + lat(k)) begin
        mem_rd[k] = mem[k][pend_adr[k][11:4]];
        pend[k] = 0;
      end else begin
        mem_rd[k] = 32'hBAD00000 | 32'(cyc);
      end
      if (mem_en[k]) begin
        if (mem_we[k]) begin
          mem[k][mem_adr[k][11:4]] = mem_wd[k];
        end else begin
          pend[k]     = 1;
          pend_cyc[k] = cyc;
          pend_adr[k] = mem_adr[k];
        end
      end
    end
  end

  // Scoreboard: queue index k*5+kind, kinds 0 gnt_core, 1 gnt_dbg, 2 mem_en,
  // 3 done_core, 4 done_dbg. Entries kept sorted by expected cycle.
  typedef struct {
    int          cyc;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] rd;
  } ev_t;

  ev_t sbq [10][$];
  int  vectors = 0;
  int  misses  = 0;

  function automatic string kname(input int kind);
    case (kind)
      0: return "gnt_core";
      1: return "gnt_dbg";
      2: return "mem_en";
      3: return "done_core";
      default: return "done_dbg";
    endcase
  endfunction

  task automatic push_ev(input int qi, input ev_t e);
    int i;
    i = 0;
    while (i < sbq[qi].size() && sbq[qi][i].cyc <= e.cyc) i++;
    sbq[qi].insert(i, e);
  endtask

  task automatic observe(input int k, input int kind, input logic we_o,
                         input logic [31:0] adr_o, input logic [31:0] wd_o,
                         input logic [31:0] rd_o);
    ev_t e;
    bit  bad;
    vectors++;
    if (sbq[k*5+kind].size() == 0) begin
      misses++;
      $display("FAIL %s dut%0d: unexpected at cycle %0d, required no event", kname(kind), k, cyc);
      return;
    end
    e = sbq[k*5+kind].pop_front();
    bad = (e.cyc != cyc);
    if (kind == 2) bad = bad || (e.we !== we_o) || (e.adr !== adr_o) || (e.wd !== wd_o);
    if (kind >= 3) bad = bad || (e.rd !== rd_o);
    if (bad) begin
      misses++;
      $display("FAIL %s dut%0d: got cycle %0d we=%b adr=%h wd=%h rd=%h, required cycle %0d we=%b adr=%h wd=%h rd=%h",
               kname(kind), k, cyc, we_o, adr_o, wd_o, rd_o, e.cyc, e.we, e.adr, e.wd, e.rd);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rstn[k]) begin
        vectors++;
        if (gnt[k][0] || gnt[k][1] || done[k][0] || done[k][1] || mem_en[k] || mem_we[k] ||
            mem_adr[k] != 0 || mem_wd[k] != 0 || rd[k][0] != 0 || rd[k][1] != 0) begin
          misses++;
          $display("FAIL reset_outputs dut%0d cycle %0d: gnt=%b%b done=%b%b en=%b we=%b adr=%h wd=%h rd=%h/%h, required all 0",
                   k, cyc, gnt[k][0], gnt[k][1], done[k][0], done[k][1], mem_en[k], mem_we[k],
                   mem_adr[k], mem_wd[k], rd[k][0], rd[k][1]);
        end
      end else begin
        for (int p = 0; p < 2; p++) begin
          if (gnt[k][p])  observe(k, p, 1'b0, 32'h0, 32'h0, 32'h0);
          if (done[k][p]) observe(k, 3 + p, 1'b0, 32'h0, 32'h0, rd[k][p]);
        end
        if (mem_en[k]) observe(k, 2, mem_we[k], mem_adr[k], mem_wd[k], 32'h0);
        else if (mem_we[k]) begin
          vectors++;
          misses++;
          $display("FAIL mem_we_alone dut%0d cycle %0d: got we=1 en=0, required we=0", k, cyc);
        end
        vectors++;
        if (stall[k] !== (req[k][0] && !done[k][0])) begin
          misses++;
          $display("FAIL core_stall dut%0d cycle %0d: got %b, required %b", k, cyc, stall[k],
                   req[k][0] && !done[k][0]);
        end
      end
    end
  end

  task automatic wait_hi(input int k, input int p, input bit on_done);
    int n;
    n = 0;
    @(negedge clk);
    while (!(on_done ? done[k][p] : gnt[k][p]) && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) begin
      vectors++;
      misses++;
      $display("FAIL timeout dut%0d port%0d: got no %s within 50 cycles, required one",
               k, p, on_done ? "done" : "gnt");
    end
  endtask

  // Issue one request; g is the hand-computed grant cycle. hold keeps req
  // high until Done (core style), otherwise req drops after the grant.
  task automatic xact(input int k, input int p, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] r, input int g,
                      input bit hold, input bit exp_done);
    ev_t e;
    e.we = w; e.adr = a; e.wd = d; e.rd = r;
    e.cyc = g;     push_ev(k*5 + p, e);
    e.cyc = g + 1; push_ev(k*5 + 2, e);
    if (exp_done) begin
      e.cyc = g + 2 + lat(k);
      push_ev(k*5 + 3 + p, e);
    end
    req[k][p] = 1'b1; we[k][p] = w; adr[k][p] = a; wd[k][p] = d;
    wait_hi(k, p, 1'b0);
    if (hold) wait_hi(k, p, 1'b1);
    @(posedge clk); #1;
    req[k][p] = 1'b0; we[k][p] = 1'b0; adr[k][p] = 32'h0; wd[k][p] = 32'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int s;
    for (int k = 0; k < 2; k++) begin
      rstn[k] = 1'b0;
      for (int p = 0; p < 2; p++) begin
        req[k][p] = 1'b0; we[k][p] = 1'b0; adr[k][p] = 32'h0; wd[k][p] = 32'h0;
      end
    end
    idle(3);
    rstn[0] = 1'b1;
    rstn[1] = 1'b1;
    idle(10);

    // Tie from reset on latency 1: core, dbg, core, dbg at +0, +4, +8, +12.
    s = cyc;
    fork
      begin
        xact(0, 0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, s, 1'b1, 1'b1);
        xact(0, 0, 1'b0, 32'h040, 32'h0, 32'h11112222, s + 8, 1'b1, 1'b1);
      end
      begin
        xact(0, 1, 1'b0, 32'h200, 32'h0, 32'hCAFEF00D, s + 4, 1'b0, 1'b1);
        xact(0, 1, 1'b1, 32'h080, 32'hA5A5A5A5, 32'hCAFEF00D, s + 12, 1'b0, 1'b1);
      end
    join
    idle(4);

    // Lone core read, latency 1: gnt +0, MemEn +1, Done +3.
    s = cyc;
    xact(0, 0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, s, 1'b1, 1'b1);
    idle(2);

    // Busy rejection: dbg rises at +1 during a core access, granted at +4.
    s = cyc;
    fork
      xact(0, 0, 1'b0, 32'h200, 32'h0, 32'hCAFEF00D, s, 1'b1, 1'b1);
      begin
        idle(1);
        xact(0, 1, 1'b0, 32'h080, 32'h0, 32'hA5A5A5A5, s + 4, 1'b0, 1'b1);
      end
    join
    idle(6);

    // Debug write, latency 3: Done at +5, RData stays at its reset value.
    s = cyc;
    xact(1, 1, 1'b1, 32'h040, 32'h12345678, 32'h0, s, 1'b0, 1'b1);
    idle(6);
    s = cyc;
    xact(1, 1, 1'b0, 32'h040, 32'h0, 32'h12345678, s, 1'b0, 1'b1);
    idle(6);

    // Reset during WAIT, latency 3: no Done, then a normal read afterwards.
    s = cyc;
    xact(1, 0, 1'b0, 32'h100, 32'h0, 32'h0, s, 1'b0, 1'b0);
    idle(1);
    rstn[1] = 1'b0;
    idle(2);
    rstn[1] = 1'b1;
    s = cyc;
    xact(1, 0, 1'b0, 32'h040, 32'h0, 32'h12345678, s, 1'b1, 1'b1);
    idle(8);

    for (int i = 0; i < 10; i++) begin
      while (sbq[i].size() > 0) begin
        ev_t e;
        e = sbq[i].pop_front();
        vectors++;
        misses++;
        $display("FAIL %s dut%0d: got nothing, required event at cycle %0d", kname(i % 5), i / 5, e.cyc);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by 100000, required $finish earlier");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the single-port unified instruction/data memory of the multi-cycle RISC-V core. It shares the memory between the core (fetch and load/store) and a debug/loader port, and grants one requester at a time with round-robin priority. Each granted access runs through a fixed issue/wait/response sequence sized to the memory's read latency. It sits between the core datapath's address mux and the memory macro.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LATENCY, 1, cycles from o_MemEn high to valid i_MemRData; legal range 1..4
- i_Clk  in  1  clock
- i_Reset  in  1  asynchronous, active-low reset
- i_CoreReq / i_DbgReq  in  1  access request; held with its payload until the matching gnt
- i_CoreWe / i_DbgWe  in  1  1 = write, 0 = read
- i_CoreAdr / i_DbgAdr  in  ADDR_W  byte address
- i_CoreWData / i_DbgWData  in  DATA_W  write data
- o_CoreGnt / o_DbgGnt  out  1  request accepted this cycle (combinational)
- o_CoreDone / o_DbgDone  out  1  one-cycle completion pulse
- o_CoreRData / o_DbgRData  out  DATA_W  read data; valid on Done, held until that port's next Done
- o_CoreStall  out  1  i_CoreReq high and o_CoreDone low; feeds the core FSM hold
- o_MemEn  out  1  memory access strobe
- o_MemWe  out  1  memory write strobe
- o_MemAdr  out  ADDR_W  memory address
- o_MemWData  out  DATA_W  memory write data
- i_MemRData  in  DATA_W  memory read data

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any request is high, assert gnt to the winner in the same cycle.
  - Capture the winner's adr, wdata, we and owner into registers.
  - Go to ISSUE.
- ISSUE:
  - o_MemEn=1; o_MemWe = captured we.
  - Load the latency counter with MEM_LATENCY.
  - Go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1: capture i_MemRData into the owner's RData register (reads only), then go to RESP.
- RESP:
  - Pulse the owner's Done for one cycle.
  - Go to IDLE.
- Arbitration:
  - A lone request always wins.
  - On a tie, the port not served last wins.
  - The last-owner register resets to DBG, so the core wins the first tie.
- Requests arriving in ISSUE, WAIT or RESP get gnt=0. They are considered only in IDLE.
- A requester may drop req before gnt. No transaction occurs.
- Writes also produce Done. RData is not updated on a write.
- o_MemAdr, o_MemWData and o_MemWe are driven from the captured registers. Address and data stay stable from ISSUE through RESP.

## Timing
- Grant at cycle n.
  - ISSUE at n+1.
  - Memory data valid at n+1+MEM_LATENCY and captured that cycle.
  - Done at n+2+MEM_LATENCY.
  - IDLE at n+3+MEM_LATENCY; the next gnt is possible that cycle.
- Throughput is one access per MEM_LATENCY+3 cycles.
- o_MemEn and o_MemWe are high exactly one cycle per access, in ISSUE.
- Reset values:
  - State IDLE, last-owner DBG.
  - All gnt, Done, o_MemEn and o_MemWe = 0.
  - o_MemAdr, o_MemWData, both RData = 0; counter = 0.
- Reset asserted mid-access (any state):
  - Immediate return to IDLE.
  - The transaction is dropped: no Done, and RData is not updated.
- Simultaneous reqs in IDLE: exactly one gnt, never both.

## Structure
- Shared package mem_arb_pkg:
  - ArbState_t enum {IDLE, ISSUE, WAIT, RESP}.
  - Owner_t enum {OWN_CORE, OWN_DBG}.
  - MEM_LATENCY_MAX = 4 constant.
- Sub-module rr_arbiter2:
  - Two-input round-robin grant with a last-owner register.
  - Updates the last-owner register on grant.
  - Instantiated once.

## Test plan
- Reset: release i_Reset -> all outputs 0, no gnt without req, o_MemEn stays 0 for 10 cycles.
- Core read, MEM_LATENCY=1: CoreReq adr 0x100 at cycle 0, memory returns 0xDEADBEEF at cycle 2.
  - CoreGnt at 0.
  - MemEn at 1 with MemAdr 0x100, MemWe 0.
  - CoreDone at 3 with CoreRData 0xDEADBEEF.
  - o_CoreStall high cycles 0..2.
- Tie arbitration: both reqs high continuously from reset.
  - Grants alternate core, dbg, core, dbg.
  - Grant cycles are 0, 4, 8, 12.
- Debug write, MEM_LATENCY=3: DbgReq We=1 adr 0x40 data 0x12345678 at cycle 0.
  - MemEn and MemWe high only at cycle 1 with that adr and data.
  - DbgDone at 5; DbgRData unchanged.
- Busy rejection: DbgReq rises at cycle 1 during a core access.
  - DbgGnt stays 0 until IDLE at cycle 4, then asserts at 4.
- Reset in WAIT (MEM_LATENCY=3): assert i_Reset at cycle 2 of a core read.
  - Outputs 0 immediately; no CoreDone.
  - After release, a new core read completes with normal timing.
